// File: rtl/uart_echo_checker_if.sv
// Byte-stream channel between the echo checker and the buffered UART:
// a valid/ready transmit path and a valid/yumi receive path.
interface uart_echo_checker_if;
    logic       tx_v_o;
    logic       tx_ready_and_i;
    logic [7:0] tx_o;
    logic       rx_v_i;
    logic [7:0] rx_i;
    logic       rx_yumi_o;

    modport master (
        output tx_v_o, tx_o, rx_yumi_o,
        input  tx_ready_and_i, rx_v_i, rx_i
    );

    modport slave (
        input  tx_v_o, tx_o, rx_yumi_o,
        output tx_ready_and_i, rx_v_i, rx_i
    );
endinterface

// File: rtl/uart_echo_checker.sv
// Host-side UART loopback checker: streams a pattern out, checks the echo, reports pass/fail/timeout.
// Define UART_ECHO_CHECKER_INCR_PATTERN_EN to use an incrementing byte pattern instead of the LFSR.
module uart_echo_checker #(
    parameter int unsigned count_width_p     = 16,
    parameter int unsigned outstanding_els_p = 16,
    parameter int unsigned timeout_cycles_p  = 1000000,
    parameter logic [7:0]  seed_p            = 8'h01
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [count_width_p-1:0] count_i,
    uart_echo_checker_if.master      uart,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     timeout_o,
    output logic [count_width_p-1:0] error_count_o
);

    localparam int unsigned out_width_lp   = $clog2(outstanding_els_p + 1);
    localparam int unsigned timer_width_lp = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;
    localparam logic [out_width_lp-1:0]   out_max_lp    = out_width_lp'(outstanding_els_p);
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_cycles_p - 1);
    localparam logic [count_width_p-1:0]  err_sat_lp    = {count_width_p{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic [7:0] next_pattern(input logic [7:0] p);
`ifdef UART_ECHO_CHECKER_INCR_PATTERN_EN
        return p + 8'd1;
`else
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`endif
    endfunction

    state_e                      state_q, state_d;
    logic [7:0]                  tx_pat_q, tx_pat_d;
    logic [7:0]                  exp_pat_q, exp_pat_d;
    logic [count_width_p-1:0]    count_q, count_d;
    logic [count_width_p-1:0]    sent_q, sent_d;
    logic [count_width_p-1:0]    received_q, received_d;
    logic [out_width_lp-1:0]     out_q, out_d;
    logic [timer_width_lp-1:0]   timer_q, timer_d;
    logic [count_width_p-1:0]    err_q, err_d;
    logic                        timeout_q, timeout_d;
    logic                        pass_q, pass_d;

    logic running;
    logic fire;
    logic accept;
    logic rx_hit;
    logic rx_bad;

    assign running = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // tx_v_o is built only from registered state, never from tx_ready_and_i.
    assign uart.tx_v_o    = (state_q == ST_RUN) && (sent_q < count_q) && (out_q < out_max_lp);
    assign uart.tx_o      = tx_pat_q;
    assign uart.rx_yumi_o = uart.rx_v_i & ~reset;

    assign fire   = uart.tx_v_o & uart.tx_ready_and_i;
    assign accept = uart.rx_v_i;

    assign busy_o        = running;
    assign done_o        = (state_q == ST_DONE);
    assign pass_o        = pass_q;
    assign timeout_o     = timeout_q;
    assign error_count_o = err_q;

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
        state_d    = state_q;
        tx_pat_d   = tx_pat_q;
        exp_pat_d  = exp_pat_q;
        count_d    = count_q;
        sent_d     = sent_q;
        received_d = received_q;
        out_d      = out_q;
        timer_d    = timer_q;
        err_d      = err_q;
        timeout_d  = timeout_q;
        rx_hit     = 1'b0;
        rx_bad     = 1'b0;

        if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i) begin
            tx_pat_d   = seed_p;
            exp_pat_d  = seed_p;
            count_d    = count_i;
            sent_d     = '0;
            received_d = '0;
            out_d      = '0;
            timer_d    = '0;
            err_d      = '0;
            timeout_d  = 1'b0;
            state_d    = (count_i == '0) ? ST_DONE : ST_RUN;
        end else begin
            if (fire) begin
                tx_pat_d = next_pattern(tx_pat_q);
                sent_d   = sent_q + count_width_p'(1);
            end

            // Only bytes matched to an outstanding send advance the expected stream;
            // anything else in RUN/DRAIN/DONE is spurious. IDLE discards silently.
            rx_hit = accept && running && (out_q != '0);
            rx_bad = accept && (state_q != ST_IDLE)
                     && ((out_q == '0) || (uart.rx_i != exp_pat_q));

            if (rx_hit) begin
                exp_pat_d  = next_pattern(exp_pat_q);
                received_d = received_q + count_width_p'(1);
            end

            if (fire && !rx_hit) begin
                out_d = out_q + out_width_lp'(1);
            end else if (!fire && rx_hit) begin
                out_d = out_q - out_width_lp'(1);
            end

            if (rx_bad && (err_q != err_sat_lp)) begin
                err_d = err_q + count_width_p'(1);
            end

            if (running) begin
                if (fire || accept) begin
                    timer_d = '0;
                end else if (timer_q == timer_last_lp) begin
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + timer_width_lp'(1);
                end

                if (timeout_d || (received_d == count_q)) begin
                    state_d = ST_DONE;
                end else if (sent_d == count_q) begin
                    state_d = ST_DRAIN;
                end
            end
        end

        pass_d = (state_d == ST_DONE) && (err_d == '0) && !timeout_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_pat_q   <= seed_p;
            exp_pat_q  <= seed_p;
            count_q    <= '0;
            sent_q     <= '0;
            received_q <= '0;
            out_q      <= '0;
            timer_q    <= '0;
            err_q      <= '0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q    <= state_d;
            tx_pat_q   <= tx_pat_d;
            exp_pat_q  <= exp_pat_d;
            count_q    <= count_d;
            sent_q     <= sent_d;
            received_q <= received_d;
            out_q      <= out_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
        end
    end

endmodule
